// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing both ports of a true dual-port RAM among N_REQ requesters.
// Optional feature: define DPRAM_ARB_COLLISION_CNT_EN to add the collision_cnt output.
module dpram_port_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rvalid,
    output logic [N_REQ*DATA_WIDTH-1:0] rdata,
`ifdef DPRAM_ARB_COLLISION_CNT_EN
    output logic [15:0]                 collision_cnt,
`endif
    output logic                        ram_we_a,
    output logic [ADDR_WIDTH-1:0]       ram_addr_a,
    output logic [DATA_WIDTH-1:0]       ram_din_a,
    input  logic [DATA_WIDTH-1:0]       ram_dout_a,
    output logic                        ram_we_b,
    output logic [ADDR_WIDTH-1:0]       ram_addr_b,
    output logic [DATA_WIDTH-1:0]       ram_din_b,
    input  logic [DATA_WIDTH-1:0]       ram_dout_b
);
    localparam int              PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0]   LAST_IDX = PW'(N_REQ - 1);
    localparam logic [PW:0]     N_WIDE   = (PW + 1)'(N_REQ);

    logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];
    logic [DATA_WIDTH-1:0] rd_arr    [N_REQ];

    logic [PW-1:0] ptr;
    logic [PW-1:0] a_idx;
    logic [PW-1:0] b_idx;
    logic [PW-1:0] last_idx;
    logic [PW-1:0] tag_a;
    logic [PW-1:0] tag_b;
    logic          a_found;
    logic          b_found;
    logic          tag_a_vld;
    logic          tag_b_vld;
`ifdef DPRAM_ARB_COLLISION_CNT_EN
    logic          conflict_skip;
`endif

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            addr_arr[k]  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[k] = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Port A takes the first requester at or after ptr; port B continues the scan
    // past the A winner, skipping anything that would collide with A's address.
    always_comb begin
        logic [PW:0]   wide;
        logic [PW-1:0] idx;
        a_found = 1'b0;
        a_idx   = '0;
        b_found = 1'b0;
        b_idx   = '0;
        wide    = '0;
        idx     = '0;
`ifdef DPRAM_ARB_COLLISION_CNT_EN
        conflict_skip = 1'b0;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            wide = {1'b0, ptr} + (PW + 1)'(k);
            if (wide >= N_WIDE) wide = wide - N_WIDE;
            idx = wide[PW-1:0];
            if (!a_found && req[idx]) begin
                a_found = 1'b1;
                a_idx   = idx;
            end
        end
        for (int k = 1; k < N_REQ; k++) begin
            wide = {1'b0, a_idx} + (PW + 1)'(k);
            if (wide >= N_WIDE) wide = wide - N_WIDE;
            idx = wide[PW-1:0];
            if (a_found && !b_found && req[idx]) begin
                if (addr_arr[idx] == addr_arr[a_idx] && (req_we[idx] || req_we[a_idx])) begin
`ifdef DPRAM_ARB_COLLISION_CNT_EN
                    conflict_skip = 1'b1;
`endif
                end else begin
                    b_found = 1'b1;
                    b_idx   = idx;
                end
            end
        end
    end

    assign last_idx = b_found ? b_idx : a_idx;

    always_comb begin
        gnt        = '0;
        ram_we_a   = 1'b0;
        ram_we_b   = 1'b0;
        ram_addr_a = addr_arr[a_idx];
        ram_din_a  = wdata_arr[a_idx];
        ram_addr_b = addr_arr[b_idx];
        ram_din_b  = wdata_arr[b_idx];
        if (rst_n) begin
            if (a_found) begin
                gnt[a_idx] = 1'b1;
                ram_we_a   = req_we[a_idx];
            end
            if (b_found) begin
                gnt[b_idx] = 1'b1;
                ram_we_b   = req_we[b_idx];
            end
        end
    end

    // Read tags remember who owns the RAM output arriving on the next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            tag_a     <= '0;
            tag_b     <= '0;
            tag_a_vld <= 1'b0;
            tag_b_vld <= 1'b0;
        end else begin
            if (a_found) begin
                ptr <= (last_idx == LAST_IDX) ? '0 : last_idx + PW'(1);
            end
            tag_a     <= a_idx;
            tag_b     <= b_idx;
            tag_a_vld <= a_found && !req_we[a_idx];
            tag_b_vld <= b_found && !req_we[b_idx];
        end
    end

    always_comb begin
        rvalid = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rd_arr[k] = '0;
        end
        if (rst_n && tag_a_vld) begin
            rvalid[tag_a] = 1'b1;
            rd_arr[tag_a] = ram_dout_a;
        end
        if (rst_n && tag_b_vld) begin
            rvalid[tag_b] = 1'b1;
            rd_arr[tag_b] = ram_dout_b;
        end
    end

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd_arr[k];
        end
    end

`ifdef DPRAM_ARB_COLLISION_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collision_cnt <= '0;
        end else if (conflict_skip && collision_cnt != 16'hFFFF) begin
            collision_cnt <= collision_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Self-checking bench for dpram_port_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin reference model and a golden memory image.
module tb_dpram_port_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N-1:0]      req_we;
    logic [AW-1:0]     t_addr  [N];
    logic [DW-1:0]     t_wdata [N];
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [N*DW-1:0]   rdata;
    logic [15:0]       collision_cnt;
    logic              ram_we_a, ram_we_b;
    logic [AW-1:0]     ram_addr_a, ram_addr_b;
    logic [DW-1:0]     ram_din_a, ram_din_b;
    logic [DW-1:0]     ram_dout_a, ram_dout_b;
    logic [DW-1:0]     mem  [1<<AW];
    logic [DW-1:0]     gold [1<<AW];

    int checks;
    int errors;
    int m_ptr;
    int e_ga;
    int e_gb;
    int e_cnt;
    bit e_coll;
    bit e_rv [N];
    logic [DW-1:0] e_rd [N];

    dpram_port_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
`ifdef DPRAM_ARB_COLLISION_CNT_EN
        .collision_cnt (collision_cnt),
`endif
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_dout_a (ram_dout_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_din_b  (ram_din_b),
        .ram_dout_b (ram_dout_b)
    );

`ifndef DPRAM_ARB_COLLISION_CNT_EN
    assign collision_cnt = 16'd0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = t_addr[i];
            req_wdata[i*DW +: DW] = t_wdata[i];
        end
    end

    // Stand-in dual-port RAM: registered read, read-before-write.
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
        ram_dout_a <= mem[ram_addr_a];
        ram_dout_b <= mem[ram_addr_b];
    end

    // Reference arbitration straight from the round-robin rules, using modulo arithmetic.
    function automatic void arb_model(output int ga, output int gb, output bit coll);
        ga   = -1;
        gb   = -1;
        coll = 1'b0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (ga < 0 && req[i]) ga = i;
        end
        if (ga >= 0) begin
            for (int k = 1; k < N; k++) begin
                int j;
                j = (ga + k) % N;
                if (gb < 0 && req[j]) begin
                    if (t_addr[j] == t_addr[ga] && (req_we[j] || req_we[ga])) coll = 1'b1;
                    else gb = j;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g;
        g = '0;
        if (e_ga >= 0) g[e_ga] = 1'b1;
        if (e_gb >= 0) g[e_gb] = 1'b1;
        return g;
    endfunction

    function automatic logic [N-1:0] exp_rvalid();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = e_rv[i] && rst_n;
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_rdata();
        logic [N*DW-1:0] d;
        d = '0;
        for (int i = 0; i < N; i++) if (e_rv[i] && rst_n) d[i*DW +: DW] = e_rd[i];
        return d;
    endfunction

    task automatic eval_cycle();
        @(negedge clk);
        if (rst_n) arb_model(e_ga, e_gb, e_coll);
        else begin
            e_ga   = -1;
            e_gb   = -1;
            e_coll = 1'b0;
        end
    endtask

    task automatic commit_cycle();
        @(posedge clk);
        for (int i = 0; i < N; i++) e_rv[i] = 1'b0;
        if (!rst_n) begin
            m_ptr = 0;
            e_cnt = 0;
        end else begin
            if (e_ga >= 0 && !req_we[e_ga]) begin
                e_rv[e_ga] = 1'b1;
                e_rd[e_ga] = gold[t_addr[e_ga]];
            end
            if (e_gb >= 0 && !req_we[e_gb]) begin
                e_rv[e_gb] = 1'b1;
                e_rd[e_gb] = gold[t_addr[e_gb]];
            end
            if (e_ga >= 0 && req_we[e_ga]) gold[t_addr[e_ga]] = t_wdata[e_ga];
            if (e_gb >= 0 && req_we[e_gb]) gold[t_addr[e_gb]] = t_wdata[e_gb];
            if (e_ga >= 0) m_ptr = ((e_gb >= 0 ? e_gb : e_ga) + 1) % N;
            if (e_coll && e_cnt < 65535) e_cnt++;
        end
        #1;
        if (e_ga >= 0) req[e_ga] = 1'b0;
        if (e_gb >= 0) req[e_gb] = 1'b0;
    endtask

    task automatic set_req(input int i, input bit we, input int addr, input int wdata);
        req[i]     = 1'b1;
        req_we[i]  = we;
        t_addr[i]  = AW'(addr);
        t_wdata[i] = DW'(wdata);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req    = '0;
        req_we = '0;
        repeat (2) begin
            eval_cycle();
            checks++;
            if (gnt !== '0 || ram_we_a !== 1'b0 || ram_we_b !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_cmd: gnt=%b we_a=%b we_b=%b, required all 0", gnt, ram_we_a, ram_we_b);
            end
            checks++;
            if (rvalid !== '0 || rdata !== '0) begin
                errors++;
                $display("[TB] FAIL reset_rvalid: rvalid=%b rdata=%h, required 0", rvalid, rdata);
            end
            commit_cycle();
        end
        rst_n = 1'b1;
        repeat (3) begin
            eval_cycle();
            checks++;
            if (gnt !== '0 || ram_we_a !== 1'b0 || ram_we_b !== 1'b0 || rvalid !== '0) begin
                errors++;
                $display("[TB] FAIL idle: gnt=%b we_a=%b we_b=%b rvalid=%b, required all 0",
                         gnt, ram_we_a, ram_we_b, rvalid);
            end
            commit_cycle();
        end
    endtask

    task automatic test_write_read();
        set_req(0, 1'b1, 3, 8'hA5);
        eval_cycle();
        checks++;
        if (gnt !== 4'b0001 || ram_we_a !== 1'b1 || ram_addr_a !== 4'd3 || ram_din_a !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL write_issue: gnt=%b we_a=%b addr_a=%h din_a=%h, required 0001 1 3 a5",
                     gnt, ram_we_a, ram_addr_a, ram_din_a);
        end
        commit_cycle();
        set_req(1, 1'b0, 3, 0);
        eval_cycle();
        checks++;
        if (gnt !== 4'b0010 || ram_we_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_issue: gnt=%b we_a=%b, required 0010 0", gnt, ram_we_a);
        end
        commit_cycle();
        eval_cycle();
        checks++;
        if (rvalid !== 4'b0010 || rdata[15:8] !== 8'hA5 || rdata !== exp_rdata()) begin
            errors++;
            $display("[TB] FAIL read_return: rvalid=%b rdata=%h, required 0010 lane1=a5 (%h)",
                     rvalid, rdata, exp_rdata());
        end
        commit_cycle();
    endtask

    task automatic test_write_conflict();
        set_req(3, 1'b0, 0, 0);
        eval_cycle();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL conflict_prelude: gnt=%b, required 1000", gnt);
        end
        commit_cycle();
        set_req(0, 1'b1, 5, 8'h11);
        set_req(2, 1'b1, 5, 8'h22);
        eval_cycle();
        checks++;
        if (gnt !== 4'b0001 || ram_we_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL conflict_first: gnt=%b we_b=%b, required 0001 0", gnt, ram_we_b);
        end
        commit_cycle();
        eval_cycle();
        checks++;
        if (gnt !== 4'b0100 || ram_we_a !== 1'b1 || ram_din_a !== 8'h22) begin
            errors++;
            $display("[TB] FAIL conflict_second: gnt=%b we_a=%b din_a=%h, required 0100 1 22",
                     gnt, ram_we_a, ram_din_a);
        end
`ifdef DPRAM_ARB_COLLISION_CNT_EN
        checks++;
        if (collision_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL collision_cnt: got %0d, required 1", collision_cnt);
        end
`endif
        commit_cycle();
    endtask

    task automatic test_rr_reads();
        set_req(3, 1'b0, 0, 0);
        eval_cycle();
        commit_cycle();
        for (int c = 0; c < 6; c++) begin
            set_req(0, 1'b0, 3, 0);
            set_req(1, 1'b0, 5, 0);
            set_req(2, 1'b0, 8, 0);
            set_req(3, 1'b0, 9, 0);
            eval_cycle();
            checks++;
            if (gnt !== ((c % 2 == 0) ? 4'b0011 : 4'b1100)) begin
                errors++;
                $display("[TB] FAIL rr_gnt[%0d]: gnt=%b, required %b", c, gnt,
                         (c % 2 == 0) ? 4'b0011 : 4'b1100);
            end
            if (c > 0) begin
                checks++;
                if (rvalid !== ((c % 2 == 1) ? 4'b0011 : 4'b1100) || rdata !== exp_rdata()) begin
                    errors++;
                    $display("[TB] FAIL rr_rvalid[%0d]: rvalid=%b rdata=%h, required %b %h", c, rvalid,
                             rdata, (c % 2 == 1) ? 4'b0011 : 4'b1100, exp_rdata());
                end
            end
            commit_cycle();
        end
        req = '0;
        eval_cycle();
        checks++;
        if (rvalid !== 4'b1100 || rdata !== exp_rdata()) begin
            errors++;
            $display("[TB] FAIL rr_drain: rvalid=%b rdata=%h, required 1100 %h", rvalid, rdata, exp_rdata());
        end
        commit_cycle();
    endtask

    task automatic test_same_addr_read();
        set_req(0, 1'b1, 7, 8'h3C);
        eval_cycle();
        commit_cycle();
        set_req(0, 1'b0, 7, 0);
        set_req(3, 1'b0, 7, 0);
        eval_cycle();
        checks++;
        if (gnt !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL same_addr_gnt: gnt=%b, required 1001", gnt);
        end
        commit_cycle();
        eval_cycle();
        checks++;
        if (rvalid !== 4'b1001 || rdata[7:0] !== 8'h3C || rdata[31:24] !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL same_addr_data: rvalid=%b rdata=%h, required 1001 3c..3c", rvalid, rdata);
        end
        commit_cycle();
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b0, 3, 0);
        eval_cycle();
        commit_cycle();
        rst_n = 1'b0;
        eval_cycle();
        checks++;
        if (rvalid !== '0 || gnt !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset: rvalid=%b gnt=%b, required 0 0", rvalid, gnt);
        end
        commit_cycle();
        rst_n = 1'b1;
        set_req(0, 1'b0, 1, 0);
        set_req(2, 1'b0, 2, 0);
        eval_cycle();
        checks++;
        if (rvalid !== '0 || gnt !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL post_reset: rvalid=%b gnt=%b, required 0000 0101", rvalid, gnt);
        end
        commit_cycle();
        eval_cycle();
        checks++;
        if (rvalid !== 4'b0101 || rdata !== exp_rdata()) begin
            errors++;
            $display("[TB] FAIL post_reset_data: rvalid=%b rdata=%h, required 0101 %h", rvalid, rdata, exp_rdata());
        end
        commit_cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom));
            end
            eval_cycle();
            checks++;
            if (gnt !== exp_gnt()) begin
                errors++;
                $display("[TB] FAIL rand_gnt[%0d]: gnt=%b, required %b", c, gnt, exp_gnt());
            end
            checks++;
            if (ram_we_a !== (e_ga >= 0 && req_we[e_ga]) || ram_we_b !== (e_gb >= 0 && req_we[e_gb])) begin
                errors++;
                $display("[TB] FAIL rand_we[%0d]: we_a=%b we_b=%b, required %b %b", c, ram_we_a, ram_we_b,
                         e_ga >= 0 && req_we[e_ga], e_gb >= 0 && req_we[e_gb]);
            end
            if (e_ga >= 0) begin
                checks++;
                if (ram_addr_a !== t_addr[e_ga] || (req_we[e_ga] && ram_din_a !== t_wdata[e_ga])) begin
                    errors++;
                    $display("[TB] FAIL rand_port_a[%0d]: addr=%h din=%h, required %h %h", c, ram_addr_a,
                             ram_din_a, t_addr[e_ga], t_wdata[e_ga]);
                end
            end
            if (e_gb >= 0) begin
                checks++;
                if (ram_addr_b !== t_addr[e_gb] || (req_we[e_gb] && ram_din_b !== t_wdata[e_gb])) begin
                    errors++;
                    $display("[TB] FAIL rand_port_b[%0d]: addr=%h din=%h, required %h %h", c, ram_addr_b,
                             ram_din_b, t_addr[e_gb], t_wdata[e_gb]);
                end
            end
            checks++;
            if (rvalid !== exp_rvalid() || rdata !== exp_rdata()) begin
                errors++;
                $display("[TB] FAIL rand_read[%0d]: rvalid=%b rdata=%h, required %b %h", c, rvalid, rdata,
                         exp_rvalid(), exp_rdata());
            end
`ifdef DPRAM_ARB_COLLISION_CNT_EN
            checks++;
            if (collision_cnt !== 16'(e_cnt)) begin
                errors++;
                $display("[TB] FAIL rand_collision[%0d]: got %0d, required %0d", c, collision_cnt, e_cnt);
            end
`endif
            commit_cycle();
        end
        req = '0;
        eval_cycle();
        checks++;
        if (rvalid !== exp_rvalid() || rdata !== exp_rdata() || gnt !== '0) begin
            errors++;
            $display("[TB] FAIL rand_drain: rvalid=%b rdata=%h gnt=%b, required %b %h 0", rvalid, rdata, gnt,
                     exp_rvalid(), exp_rdata());
        end
        commit_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_ptr  = 0;
        e_ga   = -1;
        e_gb   = -1;
        e_cnt  = 0;
        e_coll = 1'b0;
        rst_n  = 1'b0;
        req    = '0;
        req_we = '0;
        for (int i = 0; i < N; i++) begin
            e_rv[i]    = 1'b0;
            e_rd[i]    = '0;
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]  = '0;
            gold[i] = '0;
        end
        test_reset();
        test_write_read();
        test_write_conflict();
        test_rr_reads();
        test_same_addr_read();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
